imem_loader: RTL and testbench

//  Writer side of the instruction-memory interface: receives a framed byte stream
//  and writes 32-bit words into instruction memory while holding the CPU in reset.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_if.sv | 32 +++
 rtl/imem_loader_byte_packer.sv | 33 +++
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state encoding, the frame sync byte and the length-limit helper.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Number of 32-bit words that fit in a 2**addr_w byte memory.
  function automatic int unsigned max_words(input int unsigned addr_w);
    return (32'd1 << addr_w) >> 2;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, memory-write and status signals of the loader, grouped as one bundle.
// rx handshake: a byte moves on a rising edge where rx_valid and rx_ready are both 1;
// rx_valid may drop at any time and rx_ready never depends combinationally on rx_valid.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  import imem_loader_pkg::*;

  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  state_t            state;

  modport master (
    input  start, rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err, state
  );

  modport slave (
    output start, rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err, state
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles four stream bytes into a little-endian word and pulses word_ready
// for one cycle once the fourth byte has been shifted in.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [1:0]  count,
  output logic [31:0] word,
  output logic        word_ready
);

  // Bytes enter at the top lane and move down, so the first byte ends in [7:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= 2'd0;
      word       <= 32'd0;
      word_ready <= 1'b0;
    end else if (clear) begin
      count      <= 2'd0;
      word       <= 32'd0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= byte_valid && (count == 2'd3);
      if (byte_valid) begin
        word  <= {byte_in, word[31:8]};
        count <= count + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Frame-driven instruction-memory writer: parses A5/length/data/checksum frames,
// writes whole words and releases cpu_hold only after a checksum-valid image.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.master bus
);

  localparam int unsigned MEM_BYTES = 32'd1 << ADDR_W;

  state_t            state;
  logic              rx_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              hold_q;
  logic [7:0]        len_lo;
  logic [15:0]       n_words;
  logic [ADDR_W-3:0] word_idx;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        csum;

  logic              accept;
  logic [15:0]       len_n;
  logic              len_ok;
  logic              last_word;
  logic              pk_clear;
  logic              pk_valid;
  logic [1:0]        pk_count;
  logic [31:0]       pk_word;
  logic              pk_ready;

  assign accept   = bus.rx_valid && rx_ready_q;
  assign len_n    = {bus.rx_data, len_lo};
  assign pk_clear = (state == S_LEN_HI) && accept;
  assign pk_valid = (state == S_DATA) && accept;

  // Length is judged on the full 16-bit value, before any narrowing to word_idx.
  assign len_ok = (len_n != 16'd0)
               && (32'(len_n) <= max_words(ADDR_W))
               && (32'(BASE_ADDR) + (32'(len_n) << 2) <= MEM_BYTES);

  assign last_word = (16'(word_idx) == n_words - 16'd1);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_in    (bus.rx_data),
    .count      (pk_count),
    .word       (pk_word),
    .word_ready (pk_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= 1'b1;
      len_lo     <= 8'd0;
      n_words    <= 16'd0;
      word_idx   <= '0;
      addr_q     <= '0;
      csum       <= 8'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            state      <= S_SYNC;
            rx_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= 1'b1;
          end
        end
        S_SYNC: begin
          if (accept && bus.rx_data == SYNC_BYTE) state <= S_LEN_LO;
        end
        S_LEN_LO: begin
          if (accept) begin
            len_lo <= bus.rx_data;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            n_words  <= len_n;
            word_idx <= '0;
            csum     <= 8'd0;
            addr_q   <= ADDR_W'(BASE_ADDR);
            if (len_ok) begin
              state <= S_DATA;
            end else begin
              state      <= S_ERROR;
              rx_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
            end
          end
        end
        S_DATA: begin
          // The write cycle after each fourth byte is a bubble with rx_ready low.
          if (pk_ready) begin
            word_idx   <= word_idx + (ADDR_W-2)'(1);
            addr_q     <= addr_q + ADDR_W'(4);
            rx_ready_q <= 1'b1;
            if (last_word) state <= S_CSUM;
          end else if (pk_valid) begin
            csum <= csum ^ bus.rx_data;
            if (pk_count == 2'd3) rx_ready_q <= 1'b0;
          end
        end
        S_CSUM: begin
          if (accept) begin
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (bus.rx_data == csum) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              hold_q <= 1'b0;
            end else begin
              state <= S_ERROR;
              err_q <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = pk_ready;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = pk_word;
  assign bus.cpu_hold  = hold_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a frame-level model predicts the word writes
// and the final outcome; a negedge monitor checks every write against it.
module tb_imem_loader;

  localparam int ADDR_W    = 10;
  localparam int BASE_ADDR = 0;
  localparam int MEM_BYTES = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]        frame[$];
  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic              exp_done;
  logic              exp_err;
  logic [7:0]        model_csum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Frame-level model: skip to sync, read the length, form words, compare checksum.
  task automatic build_expect();
    int i = 0;
    int n;
    logic [7:0] cs = 8'd0;
    while (i < frame.size() && frame[i] != 8'hA5) i++;
    n = int'({frame[i+2], frame[i+1]});
    i = i + 3;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n == 0 || n > MEM_BYTES / 4 || BASE_ADDR + 4 * n > MEM_BYTES) begin
      exp_err = 1'b1;
    end else begin
      for (int w = 0; w < n; w++) begin
        exp_q.push_back({frame[i+4*w+3], frame[i+4*w+2], frame[i+4*w+1], frame[i+4*w]});
        exp_addr_q.push_back(ADDR_W'(BASE_ADDR + 4 * w));
        for (int b = 0; b < 4; b++) cs = cs ^ frame[i+4*w+b];
      end
      exp_done = (cs == frame[i+4*n]);
      exp_err  = !exp_done;
    end
    model_csum = cs;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_busy", 32'(bus.busy), 32'd1);
    chk("start_hold", 32'(bus.cpu_hold), 32'd1);
    chk("start_done_clr", 32'(bus.done), 32'd0);
    chk("start_err_clr", 32'(bus.err), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: got 0 required 1 for byte %h", b);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic send_frame(input bit gaps);
    for (int k = 0; k < frame.size(); k++) begin
      if (gaps && k >= 3 && $urandom_range(0, 1) == 1) begin
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      send_byte(frame[k]);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    int t = 0;
    while (!(bus.done || bus.err) && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(bus.done), 32'(exp_done));
    chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'(!exp_done));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_frame(input string tag, input bit gaps);
    build_expect();
    start_pulse();
    send_frame(gaps);
    finish_frame(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  // Every write strobe must match the next modelled word and sit in a bubble.
  always @(negedge clk) begin
    if (!rst && bus.mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h required no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        chk("write_addr", 32'(bus.mem_addr), 32'(exp_addr_q.pop_front()));
        chk("write_data", bus.mem_wdata, exp_q.pop_front());
      end
      chk("rx_ready_in_write", 32'(bus.rx_ready), 32'd0);
    end
  end

  initial begin
    bus.start    = 1'b0;
    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("idle");

    // Two-word image; literal checks pin the model's word assembly and checksum.
    frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    build_expect();
    chk("model_word0", exp_q[0], 32'h44332211);
    chk("model_word1", exp_q[1], 32'h88776655);
    chk("model_addr1", 32'(exp_addr_q[1]), 32'd4);
    chk("model_csum", 32'(model_csum), 32'h88);
    chk("model_done", 32'(exp_done), 32'd1);
    exp_q.delete();
    exp_addr_q.delete();
    run_frame("t1", 1'b0);

    frame = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00,
              8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    run_frame("t2_garbage", 1'b0);

    frame = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_frame("t3_badcsum", 1'b0);
    frame = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    run_frame("t3_recover", 1'b0);

    frame = '{8'hA5, 8'h00, 8'h00};
    run_frame("t4_n0", 1'b0);
    frame = '{8'hA5, 8'h01, 8'h01};
    run_frame("t4_n257", 1'b0);

    frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    run_frame("t5_gaps", 1'b1);

    // Reset in the middle of a word: outputs must drop before the next clock edge.
    start_pulse();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
    for (int k = 0; k < frame.size(); k++) send_byte(frame[k]);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_values("t6_async");
    @(negedge clk);
    rst = 1'b0;
    frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    run_frame("t6_reload", 1'b0);

    // Largest image: 256 words filling the whole memory, last write at 0x3FC.
    frame = '{8'hA5, 8'h00, 8'h01};
    begin
      logic [7:0] cs = 8'd0;
      logic [7:0] b;
      for (int k = 0; k < MEM_BYTES; k++) begin
        b = 8'((k * 7) + (k >> 8));
        frame.push_back(b);
        cs = cs ^ b;
      end
      frame.push_back(cs);
    end
    build_expect();
    chk("model_max_last_addr", 32'(exp_addr_q[255]), 32'h3FC);
    exp_q.delete();
    exp_addr_q.delete();
    run_frame("t7_max", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
